// File: rtl/button_pkg.sv
// Shared definitions for the controller-to-command path: button bit positions,
// repeat-channel state encoding and the frame counter width.
package button_pkg;

    localparam int FRAME_W    = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    typedef logic [FRAME_W-1:0] frame_cnt_t;

endpackage

// File: rtl/repeat_channel.sv
// Delayed-auto-shift channel: one pulse on press, another DELAY frames later,
// then one every RATE frames while the button stays held.
module repeat_channel
    import button_pkg::*;
#(
    parameter int DELAY = 16,
    parameter int RATE  = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_tick,
    input  logic held,
    input  logic cancel,
    output logic fire
);

    localparam frame_cnt_t DELAY_CNT = frame_cnt_t'(DELAY);
    localparam frame_cnt_t RATE_CNT  = frame_cnt_t'(RATE);

    rep_state_e state_q, state_d;
    frame_cnt_t cnt_q, cnt_d, cnt_dec;
    logic       fire_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fire    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fire    <= fire_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_d  = 1'b0;
        cnt_dec = cnt_q - frame_cnt_t'(1);
        if (frame_tick) begin
            // A cancelled channel behaves exactly like a released one.
            if (!held || cancel) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        fire_d  = 1'b1;
                        cnt_d   = DELAY_CNT;
                        state_d = ST_DELAY;
                    end
                    ST_DELAY: begin
                        if (cnt_dec == '0) begin
                            fire_d  = 1'b1;
                            cnt_d   = RATE_CNT;
                            state_d = ST_REPEAT;
                        end else begin
                            cnt_d = cnt_dec;
                        end
                    end
                    ST_REPEAT: begin
                        if (cnt_dec == '0) begin
                            fire_d = 1'b1;
                            cnt_d  = RATE_CNT;
                        end else begin
                            cnt_d = cnt_dec;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_command_gen.sv
// Turns per-frame controller snapshots into single-cycle Tetris command pulses.
// buttons_valid is a one-cycle strobe with no back-pressure: each high cycle is one frame.
module button_command_gen
    import button_pkg::*;
#(
    parameter int DAS_FRAMES  = 16,
    parameter int ARR_FRAMES  = 6,
    parameter int DROP_FRAMES = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] buttons,
    input  logic       buttons_valid,
    output logic       cmd_left,
    output logic       cmd_right,
    output logic       cmd_soft_drop,
    output logic       cmd_hard_drop,
    output logic       cmd_rot_cw,
    output logic       cmd_rot_ccw,
    output logic       cmd_pause
);

    logic [7:0] prev_buttons;
    logic [7:0] rise;
    logic       lr_conflict;
    logic       unused_rise;

    assign rise        = buttons & ~prev_buttons;
    assign lr_conflict = buttons[BTN_LEFT] & buttons[BTN_RIGHT];
    // Select and the repeat buttons have no press-edge command.
    assign unused_rise = ^{rise[BTN_SELECT], rise[BTN_DOWN], rise[BTN_LEFT], rise[BTN_RIGHT]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_buttons  <= '0;
            cmd_hard_drop <= 1'b0;
            cmd_rot_cw    <= 1'b0;
            cmd_rot_ccw   <= 1'b0;
            cmd_pause     <= 1'b0;
        end else begin
            cmd_hard_drop <= buttons_valid & rise[BTN_UP];
            cmd_rot_cw    <= buttons_valid & rise[BTN_A];
            cmd_rot_ccw   <= buttons_valid & rise[BTN_B];
            cmd_pause     <= buttons_valid & rise[BTN_START];
            if (buttons_valid) begin
                prev_buttons <= buttons;
            end
        end
    end

    repeat_channel #(.DELAY(DAS_FRAMES), .RATE(ARR_FRAMES)) u_left (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (buttons_valid),
        .held       (buttons[BTN_LEFT]),
        .cancel     (lr_conflict),
        .fire       (cmd_left)
    );

    repeat_channel #(.DELAY(DAS_FRAMES), .RATE(ARR_FRAMES)) u_right (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (buttons_valid),
        .held       (buttons[BTN_RIGHT]),
        .cancel     (lr_conflict),
        .fire       (cmd_right)
    );

    repeat_channel #(.DELAY(DROP_FRAMES), .RATE(DROP_FRAMES)) u_down (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (buttons_valid),
        .held       (buttons[BTN_DOWN]),
        .cancel     (1'b0),
        .fire       (cmd_soft_drop)
    );

endmodule

// File: tb/tb_button_command_gen.sv
// Bench for button_command_gen: frame driver, hold-duration reference model,
// expected-vector queue checked one cycle after every strobe.
module tb_button_command_gen;

    localparam int DAS  = 16;
    localparam int ARR  = 6;
    localparam int DROP = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] buttons = 8'h00;
    logic       buttons_valid = 1'b0;
    logic       cmd_left, cmd_right, cmd_soft_drop, cmd_hard_drop;
    logic       cmd_rot_cw, cmd_rot_ccw, cmd_pause;

    button_command_gen #(
        .DAS_FRAMES  (DAS),
        .ARR_FRAMES  (ARR),
        .DROP_FRAMES (DROP)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .cmd_left      (cmd_left),
        .cmd_right     (cmd_right),
        .cmd_soft_drop (cmd_soft_drop),
        .cmd_hard_drop (cmd_hard_drop),
        .cmd_rot_cw    (cmd_rot_cw),
        .cmd_rot_ccw   (cmd_rot_ccw),
        .cmd_pause     (cmd_pause)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Vector bit order: 0 left, 1 right, 2 soft, 3 hard, 4 rot_cw, 5 rot_ccw, 6 pause
    int         total = 0;
    int         bad = 0;
    logic [6:0] exp_q[$];
    logic       valid_d = 1'b0;
    bit         mon_en = 1'b0;
    int         pulse_cnt[7];
    logic [6:0] mon_obs, mon_exp;

    // reference model: hold length per repeat channel, -1 when not held
    int         k_left = -1, k_right = -1, k_down = -1;
    logic [7:0] m_prev = 8'h00;

    function automatic bit rep_fire(input int k, input int d, input int r);
        return (k == 0) || (k >= d && ((k - d) % r) == 0);
    endfunction

    task automatic model_reset();
        k_left = -1;
        k_right = -1;
        k_down = -1;
        m_prev = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] b, output logic [6:0] e);
        logic [7:0] rise;
        bit         cancel;
        rise    = b & ~m_prev;
        cancel  = b[7] && b[6];
        k_left  = (b[6] && !cancel) ? k_left + 1 : -1;
        k_right = (b[7] && !cancel) ? k_right + 1 : -1;
        k_down  = b[5] ? k_down + 1 : -1;
        e = {rise[3], rise[1], rise[0], rise[4],
             rep_fire(k_down, DROP, DROP), rep_fire(k_right, DAS, ARR), rep_fire(k_left, DAS, ARR)};
        m_prev = b;
    endtask

    // scoreboard monitor
    always @(posedge clk) valid_d <= buttons_valid;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_obs = {cmd_pause, cmd_rot_ccw, cmd_rot_cw, cmd_hard_drop,
                       cmd_soft_drop, cmd_right, cmd_left};
            total++;
            if (valid_d) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_underflow t=%0t got=%b exp=<none>", $time, mon_obs);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_obs !== mon_exp) begin
                        bad++;
                        $display("FAIL cmd_vec t=%0t got=%b exp=%b", $time, mon_obs, mon_exp);
                    end
                end
            end else if (mon_obs !== 7'b0) begin
                bad++;
                $display("FAIL idle_quiet t=%0t got=%b exp=0000000", $time, mon_obs);
            end
            for (int i = 0; i < 7; i++) if (mon_obs[i] === 1'b1) pulse_cnt[i]++;
        end
    end

    // driver tasks
    task automatic drive_frame(input logic [7:0] b, input int gap);
        logic [6:0] e;
        @(negedge clk);
        buttons = b;
        buttons_valid = 1'b1;
        model_step(b, e);
        exp_q.push_back(e);
        repeat (gap) begin
            @(negedge clk);
            buttons_valid = 1'b0;
            buttons = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            buttons_valid = 1'b0;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 7; i++) pulse_cnt[i] = 0;
    endtask

    task automatic hold(input logic [7:0] b, input int frames);
        for (int i = 0; i < frames; i++) drive_frame(b, $urandom_range(0, 2));
    endtask

    // tests
    task automatic test_reset();
        logic [6:0] obs;
        buttons = 8'h01;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        obs = {cmd_pause, cmd_rot_ccw, cmd_rot_cw, cmd_hard_drop, cmd_soft_drop, cmd_right, cmd_left};
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0000000", obs);
        end
        reset_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        clear_counts();
        hold(8'h01, 11);
        idle(2);
        total++;
        if (pulse_cnt[4] !== 1) begin
            bad++;
            $display("FAIL rot_cw_held_count got=%0d exp=1", pulse_cnt[4]);
        end
        drive_frame(8'h00, 1);
    endtask

    task automatic test_left();
        idle(2);
        clear_counts();
        hold(8'h40, 30);
        drive_frame(8'h00, 1);
        idle(2);
        total++;
        if (pulse_cnt[0] !== 4) begin
            bad++;
            $display("FAIL left_30_count got=%0d exp=4", pulse_cnt[0]);
        end
        clear_counts();
        hold(8'h40, 10);
        drive_frame(8'h00, 1);
        idle(2);
        total++;
        if (pulse_cnt[0] !== 1) begin
            bad++;
            $display("FAIL left_short_count got=%0d exp=1", pulse_cnt[0]);
        end
    endtask

    task automatic test_conflict();
        clear_counts();
        hold(8'hC0, 5);
        hold(8'h40, 17);
        drive_frame(8'h00, 1);
        idle(2);
        total++;
        if (pulse_cnt[1] !== 0) begin
            bad++;
            $display("FAIL conflict_right_count got=%0d exp=0", pulse_cnt[1]);
        end
        total++;
        if (pulse_cnt[0] !== 2) begin
            bad++;
            $display("FAIL conflict_left_count got=%0d exp=2", pulse_cnt[0]);
        end
    endtask

    task automatic test_down_left();
        clear_counts();
        hold(8'h60, 10);
        drive_frame(8'h00, 1);
        idle(2);
        total++;
        if (pulse_cnt[2] !== 4) begin
            bad++;
            $display("FAIL soft_drop_count got=%0d exp=4", pulse_cnt[2]);
        end
        total++;
        if (pulse_cnt[0] !== 1) begin
            bad++;
            $display("FAIL down_left_count got=%0d exp=1", pulse_cnt[0]);
        end
    endtask

    task automatic test_edges();
        clear_counts();
        drive_frame(8'h1A, 1);
        drive_frame(8'h1A, 2);
        drive_frame(8'h00, 1);
        drive_frame(8'h04, 1);
        drive_frame(8'h00, 1);
        idle(2);
        total++;
        if ({pulse_cnt[6], pulse_cnt[5], pulse_cnt[3], pulse_cnt[4]} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
            bad++;
            $display("FAIL edge_counts got=pause%0d ccw%0d hard%0d cw%0d exp=1 1 1 0",
                     pulse_cnt[6], pulse_cnt[5], pulse_cnt[3], pulse_cnt[4]);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        for (int i = 0; i < 7; i++) drive_frame(8'h20, 0);
        drive_frame(8'h00, 1);
        idle(2);
        total++;
        if (pulse_cnt[2] !== 3) begin
            bad++;
            $display("FAIL b2b_soft_count got=%0d exp=3", pulse_cnt[2]);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) b = b ^ (8'h01 << $urandom_range(0, 7));
            drive_frame(b, $urandom_range(0, 3));
        end
        drive_frame(8'h00, 1);
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [6:0] e;
        logic [6:0] obs;
        hold(8'h40, 16);
        @(negedge clk);
        buttons = 8'h40;
        buttons_valid = 1'b1;
        model_step(8'h40, e);
        @(posedge clk);
        mon_en = 1'b0;
        #1;
        total++;
        if (cmd_left !== e[0]) begin
            bad++;
            $display("FAIL pre_reset_left got=%b exp=%b", cmd_left, e[0]);
        end
        reset_n = 1'b0;
        #1;
        obs = {cmd_pause, cmd_rot_ccw, cmd_rot_cw, cmd_hard_drop, cmd_soft_drop, cmd_right, cmd_left};
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%b exp=0000000", obs);
        end
        @(negedge clk);
        buttons_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        clear_counts();
        hold(8'h40, 17);
        drive_frame(8'h00, 1);
        idle(2);
        total++;
        if (pulse_cnt[0] !== 2) begin
            bad++;
            $display("FAIL post_reset_left_count got=%0d exp=2", pulse_cnt[0]);
        end
    endtask

    initial begin
        test_reset();
        test_left();
        test_conflict();
        test_down_left();
        test_edges();
        test_back_to_back();
        test_random();
        test_reset_mid();
        idle(3);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
